// File: rtl/instruction_fetcher_pkg.sv
// Shared definitions for the core control FSM and the fetch stage:
// core/fetcher state encodings and default program-memory widths.
package instruction_fetcher_pkg;

  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int DEFAULT_DATA_BITS = 16;

  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped instruction cache storage: combinational lookup, one
// synchronous write port, synchronous flush/reset of the valid bits.
module icache_array #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int ENTRIES   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [ADDR_BITS-1:0] lookup_addr,
  output logic                 hit,
  output logic [DATA_BITS-1:0] hit_data,
  input  logic                 write_en,
  input  logic [ADDR_BITS-1:0] write_addr,
  input  logic [DATA_BITS-1:0] write_data
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_BITS - IDX_W;

  logic [ENTRIES-1:0] line_valid;
  logic [TAG_W-1:0]   line_tag  [ENTRIES];
  logic [DATA_BITS-1:0] line_data [ENTRIES];

  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] write_idx;

  assign lookup_idx = lookup_addr[IDX_W-1:0];
  assign write_idx  = write_addr[IDX_W-1:0];

  assign hit      = line_valid[lookup_idx] &&
                    (line_tag[lookup_idx] == lookup_addr[ADDR_BITS-1:IDX_W]);
  assign hit_data = line_data[lookup_idx];

  // Flush takes priority over a fill on the same edge: the line stays invalid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      line_valid <= '0;
    end else if (flush) begin
      line_valid <= '0;
    end else if (write_en) begin
      line_valid[write_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (write_en) begin
      line_tag[write_idx]  <= write_addr[ADDR_BITS-1:IDX_W];
      line_data[write_idx] <= write_data;
    end
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Per-core fetch stage: serves cache hits in one cycle, otherwise performs a
// valid/ready read from program memory and fills the cache.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int PROGRAM_MEM_DATA_BITS = DEFAULT_DATA_BITS,
  parameter int CACHE_ENTRIES         = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

  fetcher_state_t state, state_next;
  logic                             valid_next;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_next;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_next;
  logic                             fill_en;
  logic                             cache_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] cache_data;

  icache_array #(
    .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS (PROGRAM_MEM_DATA_BITS),
    .ENTRIES   (CACHE_ENTRIES)
  ) u_icache (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .lookup_addr (current_pc),
    .hit         (cache_hit),
    .hit_data    (cache_data),
    .write_en    (fill_en),
    .write_addr  (mem_read_address),
    .write_data  (mem_read_data)
  );

  assign fetcher_state = state;

  always_comb begin
    state_next = state;
    valid_next = mem_read_valid;
    addr_next  = mem_read_address;
    instr_next = instruction;
    fill_en    = 1'b0;
    case (state)
      FETCHER_IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (cache_hit) begin
            instr_next = cache_data;
            state_next = FETCHER_FETCHED;
          end else begin
            valid_next = 1'b1;
            addr_next  = current_pc;
            state_next = FETCHER_FETCHING;
          end
        end
      end
      // Request address is held, so it doubles as the fill address.
      FETCHER_FETCHING: begin
        if (mem_read_ready) begin
          instr_next = mem_read_data;
          valid_next = 1'b0;
          fill_en    = 1'b1;
          state_next = FETCHER_FETCHED;
        end
      end
      FETCHER_FETCHED: begin
        if (core_state == CORE_DECODE) begin
          state_next = FETCHER_IDLE;
        end
      end
      default: state_next = FETCHER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= FETCHER_IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
    end else begin
      state            <= state_next;
      mem_read_valid   <= valid_next;
      mem_read_address <= addr_next;
      instruction      <= instr_next;
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: misses, hits, conflicts, flush,
// reset mid-request and spurious memory responses.
module tb_instruction_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        flush;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;

  int n_checks = 0;
  int n_fail   = 0;
  int req_count = 0;
  logic prev_valid = 1'b0;

  localparam logic [2:0] S_IDLE = 3'b000, S_FETCHING = 3'b001, S_FETCHED = 3'b010;

  instruction_fetcher #(
    .PROGRAM_MEM_ADDR_BITS (8),
    .PROGRAM_MEM_DATA_BITS (16),
    .CACHE_ENTRIES         (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .flush            (flush),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction)
  );

  always #5 clk = ~clk;

  // Counts distinct memory requests (rising edges of mem_read_valid).
  always @(posedge clk) begin
    if (mem_read_valid && !prev_valid) req_count++;
    prev_valid <= mem_read_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full FETCH..DECODE round trip. For a miss, ready arrives after
  // 'hold' cycles of valid; flush_on_fill raises flush on the ready edge.
  task automatic do_fetch(input string tag, input logic [7:0] pc, input int hold,
                          input logic [15:0] data, input bit expect_hit,
                          input bit flush_on_fill);
    int start_reqs;
    start_reqs = req_count;
    core_state = 3'b001;
    current_pc = pc;
    tick();
    if (expect_hit) begin
      check_eq({tag, "_hit_state"}, 32'(fetcher_state), 32'(S_FETCHED));
      check_eq({tag, "_hit_valid"}, 32'(mem_read_valid), 32'd0);
      check_eq({tag, "_hit_instr"}, 32'(instruction), 32'(data));
    end else begin
      check_eq({tag, "_req_state"}, 32'(fetcher_state), 32'(S_FETCHING));
      check_eq({tag, "_req_valid"}, 32'(mem_read_valid), 32'd1);
      check_eq({tag, "_req_addr"}, 32'(mem_read_address), 32'(pc));
      for (int i = 1; i < hold; i++) begin
        tick();
        check_eq({tag, "_hold_valid"}, 32'(mem_read_valid), 32'd1);
        check_eq({tag, "_hold_addr"}, 32'(mem_read_address), 32'(pc));
      end
      mem_read_ready = 1'b1;
      mem_read_data  = data;
      flush = flush_on_fill;
      tick();
      mem_read_ready = 1'b0;
      mem_read_data  = 16'h0000;
      flush = 1'b0;
      check_eq({tag, "_fill_state"}, 32'(fetcher_state), 32'(S_FETCHED));
      check_eq({tag, "_fill_valid"}, 32'(mem_read_valid), 32'd0);
      check_eq({tag, "_fill_instr"}, 32'(instruction), 32'(data));
    end
    check_eq({tag, "_reqs"}, 32'(req_count - start_reqs), expect_hit ? 32'd0 : 32'd1);
    core_state = 3'b010;
    tick();
    check_eq({tag, "_decode_idle"}, 32'(fetcher_state), 32'(S_IDLE));
    check_eq({tag, "_decode_instr"}, 32'(instruction), 32'(data));
    core_state = 3'b000;
  endtask

  initial begin
    reset = 1'b0;
    core_state = 3'b000;
    current_pc = 8'h00;
    flush = 1'b0;
    mem_read_ready = 1'b0;
    mem_read_data = 16'h0000;
    tick();
    tick();
    check_eq("rst_state", 32'(fetcher_state), 32'(S_IDLE));
    check_eq("rst_valid", 32'(mem_read_valid), 32'd0);
    check_eq("rst_addr", 32'(mem_read_address), 32'd0);
    check_eq("rst_instr", 32'(instruction), 32'd0);
    reset = 1'b1;
    tick();

    // Cold miss, then hit.
    do_fetch("cold", 8'h05, 3, 16'h3A21, 1'b0, 1'b0);
    do_fetch("hit", 8'h05, 1, 16'h3A21, 1'b1, 1'b0);

    // Conflict on index 1: 0x09 evicts 0x05.
    do_fetch("conf09", 8'h09, 1, 16'h1111, 1'b0, 1'b0);
    do_fetch("conf05", 8'h05, 2, 16'h3A21, 1'b0, 1'b0);
    do_fetch("conf09b", 8'h09, 1, 16'h1111, 1'b0, 1'b0);
    do_fetch("conf05b", 8'h05, 1, 16'h3A21, 1'b0, 1'b0);

    // Flush pulse while idle invalidates 0x05.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    do_fetch("flush05", 8'h05, 1, 16'h3A21, 1'b0, 1'b0);

    // Flush on the fill edge: instruction delivered, line stays invalid.
    do_fetch("flfill", 8'h0C, 2, 16'h5C5C, 1'b0, 1'b1);
    do_fetch("flfill2", 8'h0C, 1, 16'h5C5C, 1'b0, 1'b0);
    do_fetch("flfill3", 8'h0C, 1, 16'h5C5C, 1'b1, 1'b0);

    // Flush on the same edge as a lookup: lookup still sees the old line.
    core_state = 3'b001;
    current_pc = 8'h0C;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flook_state", 32'(fetcher_state), 32'(S_FETCHED));
    check_eq("flook_instr", 32'(instruction), 32'h5C5C);
    core_state = 3'b010;
    tick();
    core_state = 3'b000;
    do_fetch("flook_after", 8'h0C, 1, 16'h5C5C, 1'b0, 1'b0);

    // Spurious ready in IDLE with a non-FETCH core state.
    core_state = 3'b010;
    current_pc = 8'h0C;
    mem_read_ready = 1'b1;
    mem_read_data = 16'hBEEF;
    tick();
    tick();
    mem_read_ready = 1'b0;
    check_eq("spur_idle_state", 32'(fetcher_state), 32'(S_IDLE));
    check_eq("spur_idle_valid", 32'(mem_read_valid), 32'd0);
    check_eq("spur_idle_instr", 32'(instruction), 32'h5C5C);
    core_state = 3'b000;
    do_fetch("spur_hit", 8'h0C, 1, 16'h5C5C, 1'b1, 1'b0);

    // Spurious ready while FETCHED.
    core_state = 3'b001;
    current_pc = 8'h0C;
    tick();
    mem_read_ready = 1'b1;
    mem_read_data = 16'hDEAD;
    tick();
    tick();
    mem_read_ready = 1'b0;
    check_eq("spur_fd_state", 32'(fetcher_state), 32'(S_FETCHED));
    check_eq("spur_fd_valid", 32'(mem_read_valid), 32'd0);
    check_eq("spur_fd_instr", 32'(instruction), 32'h5C5C);
    core_state = 3'b010;
    tick();
    core_state = 3'b000;

    // Reset two cycles after a request; a late ready is ignored.
    core_state = 3'b001;
    current_pc = 8'h22;
    tick();
    check_eq("rmid_valid", 32'(mem_read_valid), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    check_eq("rmid_state", 32'(fetcher_state), 32'(S_IDLE));
    check_eq("rmid_valid0", 32'(mem_read_valid), 32'd0);
    check_eq("rmid_instr", 32'(instruction), 32'd0);
    reset = 1'b1;
    core_state = 3'b000;
    mem_read_ready = 1'b1;
    mem_read_data = 16'hFFFF;
    tick();
    mem_read_ready = 1'b0;
    mem_read_data = 16'h0000;
    check_eq("late_state", 32'(fetcher_state), 32'(S_IDLE));
    check_eq("late_instr", 32'(instruction), 32'd0);
    check_eq("late_valid", 32'(mem_read_valid), 32'd0);
    do_fetch("after_rst", 8'h22, 1, 16'h7777, 1'b0, 1'b0);
    do_fetch("after_rst0C", 8'h0C, 1, 16'h5C5C, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
